// File: rtl/alu_div_pkg.sv
// Shared types and constants for the iterative divide/remainder unit.
package alu_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } div_state_e;

    localparam int unsigned DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] MIN_SIGNED = {1'b1, {(DIV_WIDTH-1){1'b0}}};

    function automatic logic is_signed_op(input div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(input div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/alu_div_unit_div_step.sv
// One restoring-division step: shift {rem, quo} left and conditionally subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           borrow;

    always_comb begin
        shifted         = {rem, quo[WIDTH-1]};
        {carry, diff}   = {1'b0, shifted} + {1'b0, 1'b1, ~divisor} + {{(WIDTH+1){1'b0}}, 1'b1};
        // diff[WIDTH] is only ever set when the subtraction borrowed, so folding it in is harmless
        borrow          = ~carry | diff[WIDTH];
        next_rem        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        next_quo        = {quo[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/alu_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit (restoring, one bit per cycle).
// Optional ALU_DIV_FAST_PATH_EN: finish in one cycle when |A| < |B|.
module alu_div_unit
    import alu_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       Op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             DivByZero
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    div_op_e          op_in;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;
    logic             busy_q, busy_d, done_q, done_d, z_q, z_d, div_by_zero_q, div_by_zero_d;
    logic [WIDTH-1:0] result_q, result_d, fix_res;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign op_in = div_op_e'(Op);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

`ifdef ALU_DIV_FAST_PATH_EN
    logic [WIDTH-1:0] mag_a, mag_b;
    always_comb begin
        mag_a = (is_signed_op(op_in) && A[WIDTH-1]) ? -A : A;
        mag_b = (is_signed_op(op_in) && B[WIDTH-1]) ? -B : B;
    end
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        quo_d         = quo_q;
        rem_d         = rem_q;
        dvs_d         = dvs_q;
        cnt_d         = cnt_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        dbz_d         = dbz_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_d      = result_q;
        z_d           = z_q;
        div_by_zero_d = div_by_zero_q;
        fix_res       = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Special and fast paths preload final quo/rem with no sign fixup pending
                    op_d      = op_in;
                    quo_d     = A;
                    dvs_d     = B;
                    rem_d     = '0;
                    neg_quo_d = 1'b0;
                    neg_rem_d = 1'b0;
                    dbz_d     = (B == '0);
                    busy_d    = 1'b1;
                    if (B == '0) begin
                        quo_d   = '1;
                        rem_d   = A;
                        state_d = FIX;
                    end else if (is_signed_op(op_in) && A == MIN_NEG && B == '1) begin
                        quo_d   = MIN_NEG;
                        rem_d   = '0;
                        state_d = FIX;
`ifdef ALU_DIV_FAST_PATH_EN
                    end else if (mag_a < mag_b) begin
                        quo_d   = '0;
                        rem_d   = A;
                        state_d = FIX;
`endif
                    end else begin
                        state_d = PREP;
                    end
                end
            end
            PREP: begin
                if (is_signed_op(op_q)) begin
                    quo_d     = quo_q[WIDTH-1] ? -quo_q : quo_q;
                    dvs_d     = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
                    neg_quo_d = quo_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                    neg_rem_d = quo_q[WIDTH-1];
                end
                rem_d   = '0;
                cnt_d   = CNT_W'(WIDTH - 1);
                state_d = ITER;
            end
            ITER: begin
                quo_d = step_quo;
                rem_d = step_rem;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (is_rem_op(op_q)) begin
                    fix_res = neg_rem_q ? -rem_q : rem_q;
                end else begin
                    fix_res = neg_quo_q ? -quo_q : quo_q;
                end
                result_d      = fix_res;
                z_d           = (fix_res == '0);
                div_by_zero_d = dbz_q;
                done_d        = 1'b1;
                busy_d        = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= DIV;
            quo_q         <= '0;
            rem_q         <= '0;
            dvs_q         <= '0;
            cnt_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            z_q           <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            quo_q         <= quo_d;
            rem_q         <= rem_d;
            dvs_q         <= dvs_d;
            cnt_q         <= cnt_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            dbz_q         <= dbz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_q      <= result_d;
            z_q           <= z_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Result    = result_q;
    assign Z         = z_q;
    assign DivByZero = div_by_zero_q;

endmodule

// File: tb/tb_alu_div_unit.sv
// Self-checking bench for alu_div_unit: arithmetic reference model plus directed literal checks.
module tb_alu_div_unit;
    import alu_div_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  Op;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic        Z;
    logic        DivByZero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 0;

    alu_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .busy      (busy),
        .done      (done),
        .Result    (Result),
        .Z         (Z),
        .DivByZero (DivByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RISC-V division semantics straight from SV arithmetic
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic dbz, output int lat);
        logic [31:0] ma, mb;
        dbz = (b == 32'd0);
        lat = 34;
        if (b == 32'd0) begin
            res = op[1] ? a : 32'hFFFF_FFFF;
            lat = 1;
        end else if (!op[0] && a == MIN_SIGNED && b == 32'hFFFF_FFFF) begin
            res = op[1] ? 32'd0 : MIN_SIGNED;
            lat = 1;
        end else begin
            case (op)
                2'd0:    res = $signed(a) / $signed(b);
                2'd1:    res = a / b;
                2'd2:    res = $signed(a) % $signed(b);
                default: res = a % b;
            endcase
            ma = (!op[0] && a[31]) ? -a : a;
            mb = (!op[0] && b[31]) ? -b : b;
`ifdef ALU_DIV_FAST_PATH_EN
            if (ma < mb) lat = 1;
`else
            if (ma < mb) lat = 34;
`endif
        end
    endfunction

    bit          active = 0;
    int          done_cyc = 0;
    logic [31:0] pend_res = '0;
    logic        pend_dbz = 1'b0;
    logic        m_busy = 1'b0, m_done = 1'b0, m_z = 1'b0, m_dbz = 1'b0;
    logic [31:0] m_result = '0;

    always @(posedge clk) begin
        logic        acc;
        logic [31:0] r;
        logic        d;
        int          l;
        cyc++;
        m_done = 1'b0;
        if (!rst_n) begin
            active   = 0;
            m_busy   = 1'b0;
            m_result = '0;
            m_z      = 1'b0;
            m_dbz    = 1'b0;
        end else begin
            acc = start && !active;
            if (active && cyc == done_cyc) begin
                m_result = pend_res;
                m_z      = (pend_res == 32'd0);
                m_dbz    = pend_dbz;
                m_done   = 1'b1;
                active   = 0;
            end
            if (acc) begin
                model(Op, A, B, r, d, l);
                pend_res = r;
                pend_dbz = d;
                done_cyc = cyc + l;
                active   = 1;
            end
            m_busy = active;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("result", Result, m_result);
            chk("z", {31'd0, Z}, {31'd0, m_z});
            chk("div_by_zero", {31'd0, DivByZero}, {31'd0, m_dbz});
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic z, output logic dbz, output int lat);
        int e0;
        @(negedge clk);
        start = 1'b1; Op = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                lat = cyc - e0;
                break;
            end
            @(negedge clk);
        end
        res = Result;
        z   = Z;
        dbz = DivByZero;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] t;
        case ($urandom_range(0, 7))
            0: t = 32'd0;
            1: t = MIN_SIGNED;
            2: t = 32'hFFFF_FFFF;
            3: t = $urandom_range(0, 15);
            4: begin t = $urandom_range(1, 15); t = -t; end
            5: t = $urandom_range(0, 1000);
            default: t = $urandom;
        endcase
        return t;
    endfunction

    initial begin
        logic [31:0] res;
        logic        z, dbz;
        int          lat, e0, seen;
        int          fast_lat;
`ifdef ALU_DIV_FAST_PATH_EN
        fast_lat = 1;
`else
        fast_lat = 34;
`endif
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Op = 2'd0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", Result, 32'd0);
        chk("reset_dbz", {31'd0, DivByZero}, 32'd0);
        rst_n = 1'b1;

        run_op(2'd1, 32'd100, 32'd7, res, z, dbz, lat);
        chk("divu_100_7", res, 32'd14);
        chk("divu_100_7_lat", lat, 32'd34);
        chk("divu_100_7_z", {31'd0, z}, 32'd0);
        run_op(2'd2, 32'hFFFF_FF9C, 32'd7, res, z, dbz, lat);
        chk("rem_m100_7", res, 32'hFFFF_FFFE);
        run_op(2'd0, 32'hFFFF_FF9C, 32'd7, res, z, dbz, lat);
        chk("div_m100_7", res, 32'hFFFF_FFF2);
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, res, z, dbz, lat);
        chk("div_ovf", res, 32'h8000_0000);
        chk("div_ovf_lat", lat, 32'd1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, res, z, dbz, lat);
        chk("rem_ovf", res, 32'd0);
        chk("rem_ovf_z", {31'd0, z}, 32'd1);
        run_op(2'd1, 32'd5, 32'd0, res, z, dbz, lat);
        chk("divu_by0", res, 32'hFFFF_FFFF);
        chk("divu_by0_flag", {31'd0, dbz}, 32'd1);
        run_op(2'd3, 32'd5, 32'd0, res, z, dbz, lat);
        chk("remu_by0", res, 32'd5);
        chk("remu_by0_flag", {31'd0, dbz}, 32'd1);
        run_op(2'd1, 32'd3, 32'd10, res, z, dbz, lat);
        chk("divu_3_10", res, 32'd0);
        chk("divu_3_10_lat", lat, fast_lat);
        run_op(2'd3, 32'd3, 32'd10, res, z, dbz, lat);
        chk("remu_3_10", res, 32'd3);
        chk("remu_3_10_lat", lat, fast_lat);

        // Abort: extra start while busy, then reset mid-operation
        @(negedge clk);
        start = 1'b1; Op = 2'd1; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        e0 = cyc;
        while (cyc < e0 + 9) @(negedge clk);
        start = 1'b1; A = 32'd1; B = 32'd1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", Result, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 32'd0);
        run_op(2'd1, 32'd9, 32'd3, res, z, dbz, lat);
        chk("divu_9_3", res, 32'd3);

        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 1499) != 0);
            start = ($urandom_range(0, 3) == 0);
            Op    = 2'($urandom_range(0, 3));
            A     = pick();
            B     = pick();
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (50) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
